adc_capture_readout: RTL
========================

// Module: adc_capture_readout
// PURPOSE
//  Reader for the ADC sample stream on clk357. On a trigger it de-flips each 13-bit
//  sample with the per-channel BITFLIP mask (offset-binary/inverted lines -> two's
//  complement) and stores a window of samples in a buffer. It then streams the window
//  out as bytes over a valid/ready handshake to the rs232 transmitter. One instance per channel.
// PARAMETERS
//  BITFLIP  13'h0000  XOR mask applied to adc_in (ch1 = 13'h0685, ch2 = 13'h1B88)
//  DEPTH    64        buffer depth in samples, power of two
//  ADDR_W   6         log2(DEPTH)
// PORTS
//  clk357    in   1         sample clock; the only clock
//  rst       in   1         synchronous, active-high reset
//  adc_in    in   13        raw ADC word, bit-flipped
//  trig      in   1         capture trigger, level; rising edge acts
//  win_len   in   ADDR_W+1  samples per window; 0 or >DEPTH means DEPTH; sampled at trigger
//  busy      out  1         high from trigger accept until the last byte is accepted
//  done      out  1         one-cycle pulse when the last byte is accepted
//  tx_data   out  8         byte to transmitter
//  tx_valid  out  1         tx_data valid
//  tx_ready  in   1         transmitter accepts byte when valid & ready
// BEHAVIOUR
//  - Input stage, every cycle:
//      adc_q  <= adc_in ^ BITFLIP
//      trig_q <= trig
//  - Trigger edge: trig_q == 1 while trig_q_d == 0.
//  - States: IDLE -> CAPTURE -> FETCH -> SEND_HI -> SEND_LO -> (FETCH | [CKSUM] | IDLE).
//  - IDLE
//      - On trigger edge: latch clamped win_len into len, set wr_addr = 0, set busy = 1,
//        go to CAPTURE.
//      - The first sample written is the adc_in that was present on the edge where trig
//        was first sampled high.
//  - CAPTURE
//      - Each cycle: mem[wr_addr] <= adc_q and wr_addr++.
//      - After len writes, go to FETCH with rd_addr = 0.
//      - No wrap-around: at most DEPTH writes.
//  - FETCH
//      - Synchronous buffer read, 1-cycle latency.
//      - The sample s is registered, then go to SEND_HI.
//  - SEND_HI
//      - tx_data = {s[12], s[12], s[12], s[12:8]} (sign-extended high byte), tx_valid = 1.
//  - SEND_LO
//      - tx_data = s[7:0], tx_valid = 1.
//  - Handshake
//      - tx_valid and tx_data hold stable until tx_ready.
//      - Advance only on valid & ready.
//      - tx_valid is never dropped without acceptance.
//      - With tx_ready held high, each sample costs 3 cycles.
//  - After SEND_LO is accepted:
//      - rd_addr++.
//      - If rd_addr == len: go to IDLE (or CKSUM), pulse done on that acceptance cycle,
//        drop busy the next cycle.
//      - Otherwise go to FETCH.
//  - Trigger edges in any state other than IDLE are ignored; they are not queued.
//  - A trigger present in the cycle after returning to IDLE is accepted.
//  - Reset, including mid-capture or mid-send:
//      - state = IDLE, busy = 0, done = 0, tx_valid = 0, tx_data = 8'h00.
//      - All counters = 0, adc_q = 0, trig_q = trig_q_d = 0.
//      - Buffer contents are don't-care.
//  - Arithmetic: len is ADDR_W+1 bits, so DEPTH = 64 fits in 7 bits. Addresses compare
//    against len; they do not wrap.
// CONFIGURATION
//  - ADC_CAPTURE_CKSUM_EN defined:
//      - After the last SEND_LO, a CKSUM state sends one extra byte.
//      - The byte is the XOR of all data bytes sent in the window, with the same handshake.
//      - done pulses when the checksum byte is accepted.
//  - Undefined: no checksum state. Exactly 2*len bytes are sent per window.
// TESTING
//  1. BITFLIP = 13'h0685, adc_in = 13'h056D (1000), trig pulse, win_len = 4, tx_ready = 1
//     -> bytes 03 E8 03 E8 03 E8 03 E8; done after the 8th byte.
//  2. BITFLIP = 13'h1B88, adc_in = 13'h1F80 ^ 13'h1B88 (-128), win_len = 1
//     -> bytes FF 80; with CKSUM_EN, one more byte 7F.
//  3. win_len = 0, ramp input 0,1,2,...
//     -> 64 samples captured, 128 bytes out, last pair 00 3F; no wrap.
//  4. tx_ready toggled 1-in-4 cycles
//     -> tx_data stable while tx_valid & !tx_ready; byte order and count unchanged.
//  5. Second trig edge during CAPTURE and during SEND
//     -> ignored, output identical to a single trigger; trig right after done is accepted.
//  6. rst asserted mid-SEND_LO
//     -> next cycle: tx_valid = 0, busy = 0, tx_data = 00; a new trigger restarts from sample 0.

Source files
------------

// File: rtl/adc_capture_readout.sv
// ADC window capture buffer with byte-serial readout over a valid/ready handshake.
// Optional checksum byte per window: define ADC_CAPTURE_CKSUM_EN.
module adc_capture_readout #(
    parameter logic [12:0] BITFLIP = 13'h0000,
    parameter int          DEPTH   = 64,
    parameter int          ADDR_W  = 6
) (
    input  logic            clk357,
    input  logic            rst,
    input  logic [12:0]     adc_in,
    input  logic            trig,
    input  logic [ADDR_W:0] win_len,
    output logic            busy,
    output logic            done,
    output logic [7:0]      tx_data,
    output logic            tx_valid,
    input  logic            tx_ready
);

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        FETCH,
        SEND_HI,
        SEND_LO,
        CKSUM
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);

    state_t          state_q;
    logic [12:0]     adc_q;
    logic [12:0]     adc_q_d;
    logic            trig_q;
    logic            trig_q_d;
    logic [ADDR_W:0] len_q;
    logic [ADDR_W:0] wr_q;
    logic [ADDR_W:0] rd_q;
    logic [7:0]      s_q;
    logic [7:0]      tx_data_q;
    logic            tx_valid_q;
    logic            busy_q;
`ifdef ADC_CAPTURE_CKSUM_EN
    logic [7:0]      cksum_q;
`endif

    logic [12:0]     mem [DEPTH];
    logic [12:0]     rd_word;
    logic [ADDR_W:0] len_d;
    logic            trig_edge;
    logic            last_pair;

    assign trig_edge = trig_q & ~trig_q_d;
    assign rd_word   = mem[rd_q[ADDR_W-1:0]];
    assign last_pair = (rd_q + ONE) == len_q;

    always_comb begin
        len_d = win_len;
        if (win_len == '0 || win_len > DEPTH_L) begin
            len_d = DEPTH_L;
        end
    end

    // adc_q_d lines the stored sample up with the edge trig was first seen on
    always_ff @(posedge clk357) begin
        if (rst) begin
            adc_q    <= '0;
            adc_q_d  <= '0;
            trig_q   <= 1'b0;
            trig_q_d <= 1'b0;
        end else begin
            adc_q    <= adc_in ^ BITFLIP;
            adc_q_d  <= adc_q;
            trig_q   <= trig;
            trig_q_d <= trig_q;
        end
    end

    always_ff @(posedge clk357) begin
        if (state_q == CAPTURE) begin
            mem[wr_q[ADDR_W-1:0]] <= adc_q_d;
        end
    end

    always_ff @(posedge clk357) begin
        if (rst) begin
            state_q    <= IDLE;
            len_q      <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            s_q        <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
`ifdef ADC_CAPTURE_CKSUM_EN
            cksum_q    <= '0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (trig_edge) begin
                        len_q   <= len_d;
                        wr_q    <= '0;
                        rd_q    <= '0;
                        busy_q  <= 1'b1;
                        state_q <= CAPTURE;
`ifdef ADC_CAPTURE_CKSUM_EN
                        cksum_q <= '0;
`endif
                    end
                end
                CAPTURE: begin
                    wr_q <= wr_q + ONE;
                    if ((wr_q + ONE) == len_q) begin
                        rd_q    <= '0;
                        state_q <= FETCH;
                    end
                end
                FETCH: begin
                    s_q        <= rd_word[7:0];
                    tx_data_q  <= {{3{rd_word[12]}}, rd_word[12:8]};
                    tx_valid_q <= 1'b1;
                    state_q    <= SEND_HI;
                end
                SEND_HI: begin
                    if (tx_ready) begin
                        tx_data_q <= s_q;
                        state_q   <= SEND_LO;
`ifdef ADC_CAPTURE_CKSUM_EN
                        cksum_q   <= cksum_q ^ tx_data_q;
`endif
                    end
                end
                SEND_LO: begin
                    if (tx_ready) begin
                        rd_q <= rd_q + ONE;
                        if (last_pair) begin
`ifdef ADC_CAPTURE_CKSUM_EN
                            tx_data_q <= cksum_q ^ tx_data_q;
                            state_q   <= CKSUM;
`else
                            tx_valid_q <= 1'b0;
                            tx_data_q  <= '0;
                            busy_q     <= 1'b0;
                            state_q    <= IDLE;
`endif
                        end else begin
                            tx_valid_q <= 1'b0;
                            tx_data_q  <= '0;
                            state_q    <= FETCH;
`ifdef ADC_CAPTURE_CKSUM_EN
                            cksum_q    <= cksum_q ^ tx_data_q;
`endif
                        end
                    end
                end
`ifdef ADC_CAPTURE_CKSUM_EN
                CKSUM: begin
                    if (tx_ready) begin
                        tx_valid_q <= 1'b0;
                        tx_data_q  <= '0;
                        busy_q     <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
`endif
                default: begin
                    tx_valid_q <= 1'b0;
                    tx_data_q  <= '0;
                    busy_q     <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    // done is high in the very cycle the final byte is handed over
`ifdef ADC_CAPTURE_CKSUM_EN
    assign done = tx_valid_q & tx_ready & (state_q == CKSUM);
`else
    assign done = tx_valid_q & tx_ready & (state_q == SEND_LO) & last_pair;
`endif

    assign busy     = busy_q;
    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;

endmodule
